// File: rtl/sram_1rwnr_init.sv
// sram_1rwnr_init: behavioural SRAM with one read/write port (port 0) and
// NUM_RPORTS read-only ports on a single clock. After reset the whole array
// is cleared by hardware (init_busy high); requests are ignored until done.
// Read latency is 1 or 2 cycles; each read produces a one-cycle rvalid pulse.
// Optional macro SRAM_RW_BYPASS_EN: a read colliding with a same-edge port 0
// write returns the merged (write-first) word instead of the old contents.
module sram_1rwnr_init #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_WIDTH  = 8,
  parameter int NUM_RPORTS   = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk0,
  input  logic                             rst0,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             rvalid0,
  input  logic [NUM_RPORTS-1:0]            csb_r,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr_r,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_r,
  output logic [NUM_RPORTS-1:0]            rvalid_r,
  output logic                             init_busy
);

  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NP         = NUM_RPORTS + 1;  // index 0 = port 0, i+1 = read port i

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     clear_cnt_q, clear_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [NP-1:0]           rd_req;
  logic [NP-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NP-1:0][DATA_WIDTH-1:0] rd_word;

  logic [NP-1:0][DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [NP-1:0]                 s1_vld_q;
  logic [NP-1:0][DATA_WIDTH-1:0] out_data;
  logic [NP-1:0]                 out_vld;

  // FSM and clear-counter registers
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q     <= INIT;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  // Clear sweep: carry into the extra counter bit marks the last address
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == INIT) begin
      clear_cnt_d = clear_cnt_q + 1'b1;
      if (clear_cnt_d[ADDR_WIDTH]) begin
        state_d     = READY;
        clear_cnt_d = '0;
      end
    end
  end

  // Port 0 write decode and lane merge against the current contents
  always_comb begin
    wr_en   = (state_q == READY) && !csb0 && !web0 && !rst0;
    wr_word = mem_q[addr0];
    for (int unsigned k = 0; k < NUM_WMASKS; k++) begin
      if (wmask0[k]) wr_word[k*WMASK_WIDTH +: WMASK_WIDTH] = din0[k*WMASK_WIDTH +: WMASK_WIDTH];
    end
  end

  // Array storage: clear sweep during INIT, masked writes when READY
  always_ff @(posedge clk0) begin
    if (state_q == INIT) mem_q[clear_cnt_q[ADDR_WIDTH-1:0]] <= '0;
    else if (wr_en)      mem_q[addr0] <= wr_word;
  end

  // Read request decode and array lookup (read-first unless bypass enabled)
  always_comb begin
    rd_req     = '0;
    rd_addr    = '0;
    rd_word    = '0;
    rd_req[0]  = (state_q == READY) && !csb0 && web0;
    rd_addr[0] = addr0;
    for (int unsigned i = 0; i < NUM_RPORTS; i++) begin
      rd_req[i+1]  = (state_q == READY) && !csb_r[i];
      rd_addr[i+1] = addr_r[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    for (int unsigned p = 0; p < NP; p++) begin
      rd_word[p] = mem_q[rd_addr[p]];
`ifdef SRAM_RW_BYPASS_EN
      if (wr_en && (rd_addr[p] == addr0)) rd_word[p] = wr_word;
`endif
    end
  end

  // First read stage: data holds when no read is captured
  always_comb begin
    s1_data_d = s1_data_q;
    for (int unsigned p = 0; p < NP; p++) begin
      if (rd_req[p]) s1_data_d[p] = rd_word[p];
    end
  end

  // First read stage registers
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      s1_data_q <= '0;
      s1_vld_q  <= '0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_vld_q  <= rd_req;
    end
  end

  // Any latency other than 2 is built as latency 1
  if (READ_LATENCY == 2) begin : g_lat2
    logic [NP-1:0][DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [NP-1:0]                 s2_vld_q;

    // Second stage only reloads when the first stage carries a fresh result
    always_comb begin
      s2_data_d = s2_data_q;
      for (int unsigned p = 0; p < NP; p++) begin
        if (s1_vld_q[p]) s2_data_d[p] = s1_data_q[p];
      end
    end

    // Second read stage registers
    always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
        s2_data_q <= '0;
        s2_vld_q  <= '0;
      end else begin
        s2_data_q <= s2_data_d;
        s2_vld_q  <= s1_vld_q;
      end
    end

    assign out_data = s2_data_q;
    assign out_vld  = s2_vld_q;
  end else begin : g_lat1
    assign out_data = s1_data_q;
    assign out_vld  = s1_vld_q;
  end

  // Output unpacking
  always_comb begin
    dout0     = out_data[0];
    rvalid0   = out_vld[0];
    dout_r    = '0;
    rvalid_r  = '0;
    for (int unsigned i = 0; i < NUM_RPORTS; i++) begin
      dout_r[i*DATA_WIDTH +: DATA_WIDTH] = out_data[i+1];
      rvalid_r[i]                        = out_vld[i+1];
    end
    init_busy = (state_q == INIT);
  end

endmodule

// File: doc/sram_1rwnr_init.md
Name: sram_1rwnr_init

Overview:
- Parametrised behavioural SRAM for TCAM match-table storage: one read/write port (port 0) plus NUM_RPORTS read-only ports, all on one clock.
- Adds features the single-clock-pair model lacks:
  - hardware clear of the whole array after reset;
  - configurable read latency;
  - per-port read-valid strobes;
  - defined read-during-write collision behaviour.
- Sits under the TCAM block wrapper, replacing fixed 32x256 macro models in simulation and FPGA builds.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH.
- ADDR_WIDTH, 8, address bits; depth RAM_DEPTH = 2**ADDR_WIDTH.
- WMASK_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_WIDTH.
- NUM_RPORTS, 1, number of read-only ports (1..4).
- READ_LATENCY, 1, cycles from address capture to dout; legal values 1 or 2.

Ports:
- clk0  input  1  single clock for all ports; rising edge.
- rst0  input  1  asynchronous active-high reset.
- csb0  input  1  port 0 active-low chip select.
- web0  input  1  port 0 active-low write enable.
- wmask0  input  NUM_WMASKS  per-lane write enable, 1 = write lane.
- addr0  input  ADDR_WIDTH  port 0 address.
- din0  input  DATA_WIDTH  port 0 write data.
- dout0  output  DATA_WIDTH  port 0 read data.
- rvalid0  output  1  dout0 carries fresh read data this cycle.
- csb_r  input  NUM_RPORTS  read-port active-low selects, bit i = port i.
- addr_r  input  NUM_RPORTS*ADDR_WIDTH  read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- dout_r  output  NUM_RPORTS*DATA_WIDTH  read data, packed the same way.
- rvalid_r  output  NUM_RPORTS  per-port read-valid.
- init_busy  output  1  high while the array is being cleared.

Behaviour:
- Reset values (asynchronous on rst0 assertion):
  - dout0 = 0, dout_r = 0, rvalid0 = 0, rvalid_r = 0, init_busy = 1.
  - Latency pipeline flushed; clear counter = 0; FSM = INIT.
- FSM states: INIT, READY.
  - INIT: each rising edge writes all-zero to mem[clear_cnt], then clear_cnt increments.
  - After the edge that clears address RAM_DEPTH-1, FSM moves to READY and init_busy drops to 0.
  - INIT therefore lasts exactly RAM_DEPTH edges after rst0 deasserts.
  - All csb0/csb_r requests presented during INIT are ignored: no write, no rvalid.
- READY, port 0:
  - Inputs sampled at rising edge N.
  - csb0=0, web0=0: for each lane k with wmask0[k]=1, mem[addr0][k*WMASK_WIDTH +: WMASK_WIDTH] <= din0 lane k. Other lanes are unchanged. Write is visible to any read sampled at edge N+1 or later.
  - csb0=0, web0=1: read; dout0 = mem[addr0] and rvalid0 = 1, both after edge N+READ_LATENCY-1 (visible in cycle N+READ_LATENCY).
  - Otherwise rvalid0 = 0 for the corresponding slot.
- Output hold: dout0 and dout_r hold their last read value when no read completes (no X injection). rvalid is a one-cycle pulse per completed read.
- READY, read ports: port i behaves identically to a port 0 read using csb_r[i] and its addr_r slice. Ports are independent; any number may hit the same address.
- Collision (same-edge port 0 write and read from any port to the same address): read returns the pre-write contents (read-first). Writes never fail.
- READ_LATENCY=2: one extra output register stage. Back-to-back reads sustain one result per cycle per port.
- Reset mid-operation:
  - In-flight reads are discarded and no rvalid is emitted for them.
  - A write sampled on the same edge as rst0 assertion is discarded.
  - The clear restarts from address 0 regardless of prior progress.
- Address width is exact; there is no out-of-range condition. clear_cnt is ADDR_WIDTH+1 bits so that wrap is detected.

Optional Feature:
- Macro: SRAM_RW_BYPASS_EN.
- Defined: collision reads return write-first data, i.e. the merged word (din0 lanes where wmask0=1, old lanes elsewhere), with the same latency and rvalid.
- Undefined: read-first behaviour as above.
- Non-colliding behaviour is identical in both builds.

Test Plan:
- Reset/clear: pulse rst0, hold released; init_busy=1 for exactly 256 cycles (ADDR_WIDTH=8), then 0. A port 0 read of addr 0x7F returns 0x00000000 with rvalid0=1.
- Masked write: write 0xDEADBEEF to 0x10 with wmask0=4'b1111, then 0x11223344 with wmask0=4'b0101. Read 0x10 -> 0xDE22BE44.
- Latency: READ_LATENCY=2, reads on consecutive edges to 0x01, 0x02 holding 0xA, 0xB -> rvalid0 high for 2 consecutive cycles starting 2 cycles after the first request, dout0 = 0xA then 0xB.
- Collision: mem[0x20]=0x1, same-edge port 0 write 0x2 and read port 0 read of 0x20 -> dout_r=0x1 without macro, 0x2 with SRAM_RW_BYPASS_EN. A subsequent read returns 0x2 in both builds.
- Multi-port: NUM_RPORTS=3, all ports read distinct addresses 0x03/0x04/0x05 holding 3/4/5 in one cycle -> rvalid_r=3'b111, correct slices.
- Reset mid-init and mid-read: assert rst0 at clear_cnt=100 while a read is in flight -> no rvalid, all outputs 0, init_busy remains 1 for a full 256 cycles after release.
